// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID pipeline buffer.
//   ISIZE / PC_W : default instruction and PC widths
//   NOP_INST     : instruction presented to decode when no beat is valid
//   ifid_beat_t  : one fetch beat (instruction + PC)
//   buf_state_t  : occupancy of the 2-entry skid buffer; the encoding is
//                  chosen so bit 0 is main_valid and bit 1 is skid_valid
package pipe_pkg;

  localparam int ISIZE = 19;
  localparam int PC_W  = 8;
  localparam logic [ISIZE-1:0] NOP_INST = '0;

  typedef struct packed {
    logic [ISIZE-1:0] inst;
    logic [PC_W-1:0]  pc;
  } ifid_beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } buf_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready skid register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr                  : synchronous drop of both entries (wins over loads)
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload (main entry)
//   state_o              : buffer occupancy (EMPTY/HALF/FULL)
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high; the producer holds valid and data stable until
// that edge. in_ready depends only on the state register, so there is no
// combinational path from out_ready to in_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output buf_state_t   state_o
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire, out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign state_o   = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = HALF;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Data registers are left as they are; only occupancy is cleared.
    if (clr) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/ifid_pipe_stage.sv
// IF/ID pipeline buffer: carries instruction + PC from fetch to decode
// through a 2-entry skid register, with synchronous flush, a NOP output
// mux and a saturating stall-cycle counter.
//   clk, rst_n         : clock, asynchronous active-low reset
//   flush              : kills all buffered beats and any beat offered this cycle
//   if_valid/if_ready  : fetch-side handshake; if_inst, if_pc payload
//   id_valid/id_ready  : decode-side handshake; id_inst, id_pc payload
//   stall_cnt          : edges seen with id_valid=1 and id_ready=0 (saturating)
module ifid_pipe_stage #(
  parameter int ISIZE = pipe_pkg::ISIZE,
  parameter int PC_W  = pipe_pkg::PC_W,
  parameter int CNT_W = 8,
  parameter logic [ISIZE-1:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [ISIZE-1:0] if_inst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [ISIZE-1:0] id_inst,
  output logic [PC_W-1:0]  id_pc,
  output logic [CNT_W-1:0] stall_cnt
);
  import pipe_pkg::*;

  localparam int W = ISIZE + PC_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  buf_state_t       buf_state;
  logic [W-1:0]     buf_data;
  logic             skid_in_ready;
  logic             skid_out_valid;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A flushed cycle must not load the offered beat, so valid is gated here
  // in addition to the synchronous clear inside the skid register.
  pipe_skid_reg #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .in_valid  (if_valid & ~flush),
    .in_ready  (skid_in_ready),
    .in_data   ({if_inst, if_pc}),
    .out_valid (skid_out_valid),
    .out_ready (id_ready),
    .out_data  (buf_data),
    .state_o   (buf_state)
  );

  assign if_ready = skid_in_ready;
  assign id_valid = skid_out_valid;
  assign id_inst  = id_valid ? buf_data[W-1:PC_W] : NOP_INST;
  assign id_pc    = id_valid ? buf_data[PC_W-1:0] : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Directed bench for ifid_pipe_stage: reset, streaming, backpressure,
// flush, counter saturation and a randomized run against a queue model.
module tb_ifid_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [18:0] if_inst;
  logic [7:0]  if_pc;
  logic        id_valid;
  logic        id_ready;
  logic [18:0] id_inst;
  logic [7:0]  id_pc;
  logic [7:0]  stall_cnt;

  logic        if_ready2;
  logic        id_valid2;
  logic [18:0] id_inst2;
  logic [7:0]  id_pc2;
  logic [3:0]  stall_cnt2;

  int checks = 0;
  int failures = 0;

  localparam logic [18:0] NOP = 19'b0;
  localparam logic [18:0] INST_S = 19'h3_9807;
  localparam logic [18:0] INST_A = 19'h1_1111;
  localparam logic [18:0] INST_B = 19'h2_2222;
  localparam logic [18:0] INST_C = 19'h3_3333;
  localparam logic [18:0] INST_D = 19'h4_4444;

  always #5 clk = ~clk;

  ifid_pipe_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .stall_cnt(stall_cnt)
  );

  ifid_pipe_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready2), .if_inst(if_inst), .if_pc(if_pc),
    .id_valid(id_valid2), .id_ready(id_ready), .id_inst(id_inst2), .id_pc(id_pc2),
    .stall_cnt(stall_cnt2)
  );

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    if_inst = '0;
    if_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid: got %0b expected 0", id_valid); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready: got %0b expected 1", if_ready); end
    checks++; if (id_inst !== NOP) begin failures++; $display("FAIL reset_id_inst: got %0h expected %0h", id_inst, NOP); end
    checks++; if (id_pc !== 8'h00) begin failures++; $display("FAIL reset_id_pc: got %0h expected 0", id_pc); end
    checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_traffic();
    id_ready = 1'b0;
    if_valid = 1'b1; if_inst = INST_A; if_pc = 8'd1;
    tick();
    if_inst = INST_B; if_pc = 8'd2;
    tick();
    if_valid = 1'b0;
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL midrst_full_if_ready: got %0b expected 0", if_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL midrst_id_valid: got %0b expected 0", id_valid); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL midrst_if_ready: got %0b expected 1", if_ready); end
    checks++; if (id_inst !== NOP) begin failures++; $display("FAIL midrst_id_inst: got %0h expected %0h", id_inst, NOP); end
    checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL midrst_stall_cnt: got %0d expected 0", stall_cnt); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if_valid = (i < 10);
      if_inst = INST_S;
      if_pc = 8'(i);
      @(negedge clk);
      checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL stream_if_ready[%0d]: got %0b expected 1", i, if_ready); end
      if (i > 0) begin
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stream_id_valid[%0d]: got %0b expected 1", i, id_valid); end
        checks++; if (id_pc !== 8'(i - 1)) begin failures++; $display("FAIL stream_id_pc[%0d]: got %0d expected %0d", i, id_pc, i - 1); end
        checks++; if (id_inst !== INST_S) begin failures++; $display("FAIL stream_id_inst[%0d]: got %0h expected %0h", i, id_inst, INST_S); end
      end
      tick();
    end
    if_valid = 1'b0;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_drain_valid: got %0b expected 0", id_valid); end
    checks++; if (id_inst !== NOP) begin failures++; $display("FAIL stream_drain_nop: got %0h expected %0h", id_inst, NOP); end
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    id_ready = 1'b0;
    if_valid = 1'b1; if_inst = INST_A; if_pc = 8'd1;
    @(negedge clk);
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL bp_empty_if_ready: got %0b expected 1", if_ready); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL bp_empty_id_valid: got %0b expected 0", id_valid); end
    tick();
    if_inst = INST_B; if_pc = 8'd2;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 8'd1 || id_inst !== INST_A) begin failures++; $display("FAIL bp_half_A: got v=%0b pc=%0d inst=%0h expected v=1 pc=1 inst=%0h", id_valid, id_pc, id_inst, INST_A); end
    checks++; if (stall_cnt !== 8'd0) begin failures++; $display("FAIL bp_stall0: got %0d expected 0", stall_cnt); end
    tick();
    if_valid = 1'b0;
    @(negedge clk);
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL bp_full_if_ready: got %0b expected 0", if_ready); end
    checks++; if (id_pc !== 8'd1) begin failures++; $display("FAIL bp_full_pc: got %0d expected 1", id_pc); end
    checks++; if (stall_cnt !== 8'd1) begin failures++; $display("FAIL bp_stall1: got %0d expected 1", stall_cnt); end
    tick();
    @(negedge clk);
    checks++; if (stall_cnt !== 8'd2) begin failures++; $display("FAIL bp_stall2: got %0d expected 2", stall_cnt); end
    tick();
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 8'd1) begin failures++; $display("FAIL bp_release_A: got v=%0b pc=%0d expected v=1 pc=1", id_valid, id_pc); end
    checks++; if (stall_cnt !== 8'd3) begin failures++; $display("FAIL bp_stall3: got %0d expected 3", stall_cnt); end
    tick();
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 8'd2 || id_inst !== INST_B) begin failures++; $display("FAIL bp_release_B: got v=%0b pc=%0d inst=%0h expected v=1 pc=2 inst=%0h", id_valid, id_pc, id_inst, INST_B); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL bp_half_if_ready: got %0b expected 1", if_ready); end
    tick();
    @(negedge clk);
    checks++; if (id_valid !== 1'b0 || id_inst !== NOP) begin failures++; $display("FAIL bp_drained: got v=%0b inst=%0h expected v=0 inst=%0h", id_valid, id_inst, NOP); end
    checks++; if (stall_cnt !== 8'd3) begin failures++; $display("FAIL bp_stall_hold: got %0d expected 3", stall_cnt); end
    id_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    id_ready = 1'b0;
    if_valid = 1'b1; if_inst = INST_A; if_pc = 8'd1;
    tick();
    if_inst = INST_B; if_pc = 8'd2;
    tick();
    flush = 1'b1; if_inst = INST_C; if_pc = 8'd7; id_ready = 1'b1;
    @(negedge clk);
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_if_ready: got %0b expected 0", if_ready); end
    checks++; if (stall_cnt !== 8'd1) begin failures++; $display("FAIL flush_pre_stall: got %0d expected 1", stall_cnt); end
    tick();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_id_valid: got %0b expected 0", id_valid); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL flush_if_ready: got %0b expected 1", if_ready); end
    checks++; if (id_inst !== NOP || id_pc !== 8'd0) begin failures++; $display("FAIL flush_nop: got inst=%0h pc=%0d expected inst=%0h pc=0", id_inst, id_pc, NOP); end
    checks++; if (stall_cnt !== 8'd1) begin failures++; $display("FAIL flush_stall: got %0d expected 1", stall_cnt); end
    // Flush while the stage is empty and ready: the offered beat is dropped.
    flush = 1'b1; if_valid = 1'b1; if_inst = INST_D; if_pc = 8'd9;
    @(negedge clk);
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL flush_empty_if_ready: got %0b expected 1", if_ready); end
    tick();
    flush = 1'b0; if_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost[%0d]: got v=%0b pc=%0d expected v=0", k, id_valid, id_pc); end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    id_ready = 1'b0;
    if_valid = 1'b1; if_inst = INST_A; if_pc = 8'd5;
    tick();
    if_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      checks++; if (stall_cnt2 !== 4'((k < 15) ? k : 15)) begin failures++; $display("FAIL sat_cnt4[%0d]: got %0d expected %0d", k, stall_cnt2, (k < 15) ? k : 15); end
      checks++; if (stall_cnt !== 8'(k)) begin failures++; $display("FAIL sat_cnt8[%0d]: got %0d expected %0d", k, stall_cnt, k); end
      checks++; if (id_valid2 !== 1'b1 || id_pc2 !== 8'd5 || id_inst2 !== INST_A || if_ready2 !== 1'b1) begin failures++; $display("FAIL sat_hold[%0d]: got v=%0b pc=%0d inst=%0h rdy=%0b expected v=1 pc=5 inst=%0h rdy=1", k, id_valid2, id_pc2, id_inst2, if_ready2, INST_A); end
      tick();
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [26:0] exp_q[$];
    int exp_stall;
    logic hold;
    logic up, dn;
    logic [31:0] r;
    logic [7:0] seq;
    do_reset();
    exp_q = {};
    exp_stall = 0;
    hold = 1'b0;
    seq = 8'd0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        if_valid = ($urandom_range(0, 3) != 0);
        r = $urandom;
        if_inst = r[18:0];
        if_pc = seq;
        seq = seq + 8'd1;
      end
      id_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      checks++; if (id_valid !== (exp_q.size() > 0)) begin failures++; $display("FAIL rnd_id_valid[%0d]: got %0b expected %0b", c, id_valid, exp_q.size() > 0); end
      checks++; if (if_ready !== (exp_q.size() < 2)) begin failures++; $display("FAIL rnd_if_ready[%0d]: got %0b expected %0b", c, if_ready, exp_q.size() < 2); end
      checks++; if (stall_cnt !== 8'(exp_stall)) begin failures++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", c, stall_cnt, exp_stall); end
      if (exp_q.size() > 0) begin
        checks++; if ({id_inst, id_pc} !== exp_q[0]) begin failures++; $display("FAIL rnd_data[%0d]: got %0h/%0h expected %0h/%0h", c, id_inst, id_pc, exp_q[0][26:8], exp_q[0][7:0]); end
      end else begin
        checks++; if (id_inst !== NOP || id_pc !== 8'd0) begin failures++; $display("FAIL rnd_nop[%0d]: got %0h/%0h expected %0h/0", c, id_inst, id_pc, NOP); end
      end
      up = if_valid && (exp_q.size() < 2);
      dn = (exp_q.size() > 0) && id_ready;
      if ((exp_q.size() > 0) && !id_ready && exp_stall < 255) exp_stall++;
      if (dn) void'(exp_q.pop_front());
      if (flush) exp_q = {};
      else if (up) exp_q.push_back({if_inst, if_pc});
      hold = if_valid && !up && !flush;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid_traffic();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifid_pipe_stage.md
Name: ifid_pipe_stage

Overview:
- Parametrised next-generation IF/ID pipeline buffer for the FPU pipeline. It carries instruction plus PC from fetch to decode.
- Adds valid/ready handshaking on both sides, plus a 2-entry skid so upstream ready is fully registered.
- Adds a synchronous flush and a saturating stall-cycle counter.
- Sits between the fetch unit and the decoder, replacing the plain clocked instruction latch.

Parameters:
- ISIZE, 19: instruction width in bits.
- PC_W, 8: program-counter width in bits.
- CNT_W, 8: stall counter width in bits.
- NOP_INST, 19'b0: value driven on id_inst whenever id_valid=0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered beats (branch/exception redirect).
- if_valid  in  1  fetch presents a beat.
- if_ready  out  1  stage can accept a beat.
- if_inst  in  ISIZE  fetched instruction.
- if_pc  in  PC_W  PC of the fetched instruction.
- id_valid  out  1  beat available to decode.
- id_ready  in  1  decode accepts the beat.
- id_inst  out  ISIZE  instruction to decode.
- id_pc  out  PC_W  PC to decode.
- stall_cnt  out  CNT_W  cycles with id_valid=1 and id_ready=0.

Behaviour:
- Reset: the interface is one clock; reset is asynchronous and active-low.
  - While rst_n=0: main_valid=0, skid_valid=0, stall_cnt=0.
  - Outputs during reset: id_valid=0, if_ready=1, id_inst=NOP_INST, id_pc=0.
  - Reset asserted mid-transfer drops both entries immediately.
- Handshakes:
  - Upstream transfer when if_valid and if_ready.
  - Downstream transfer when id_valid and id_ready.
  - Source must hold if_valid and data stable until accepted; the stage guarantees the same for id_*.
- State: two entries, main (drives id_*) and skid.
  - if_ready = ~skid_valid, a pure register output with no combinational path from id_ready.
- Latency and throughput:
  - A beat accepted at edge N appears on id_* after edge N.
  - Throughput is one beat per cycle with id_ready held high.
- States (main_valid, skid_valid):
  - EMPTY (0,0): an accepted beat loads main, giving HALF.
  - HALF (1,0):
    - Consumed with no input: go to EMPTY.
    - Consumed with an input beat: main reloads, stay in HALF.
    - Not consumed with an input beat: beat goes to skid, giving FULL.
    - Neither: hold.
  - FULL (1,1), if_ready=0:
    - Consumed: skid moves to main, giving HALF.
    - Not consumed: hold.
  - (0,1) is unreachable.
- Ordering: beats leave in acceptance order; no beat is duplicated or dropped except by flush or reset.
- Flush (highest priority, synchronous):
  - At the edge with flush=1, main_valid=0 and skid_valid=0.
  - Any beat offered that cycle is discarded even if if_ready=1.
  - Any beat consumed by decode that cycle still counts as consumed.
  - Next cycle: id_valid=0, if_ready=1.
- Output data: when id_valid=0, id_inst=NOP_INST and id_pc=0; the buffered data registers are not required to clear.
- stall_cnt:
  - +1 each edge where id_valid=1 and id_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Not cleared by flush.

Decomposition:
- Package pipe_pkg holds:
  - localparams ISIZE and PC_W, and NOP_INST;
  - typedef struct packed {inst, pc} ifid_beat_t;
  - typedef enum {EMPTY, HALF, FULL} buf_state_t, for bench/assertion use.
- One sub-module, pipe_skid_reg (parameter W): a generic 2-entry valid/ready skid register.
- ifid_pipe_stage instantiates pipe_skid_reg with W=ISIZE+PC_W and adds flush gating, the NOP mux and stall_cnt.

Test Plan:
- Reset mid-traffic: in FULL, pull rst_n low between edges -> id_valid=0, if_ready=1, id_inst=19'b0 immediately; stall_cnt=0.
- Streaming: id_ready=1, beats inst=19'h3_9807 pc=0..9 one per cycle -> identical sequence on id_*, one cycle later, no bubbles; if_ready never drops.
- Backpressure/skid: send A(pc=1), B(pc=2) with id_ready=0 -> FULL, if_ready=0; stall_cnt counts 1,2,...; raise id_ready -> A then B in order, no loss.
- Flush collision: in FULL, assert flush with if_valid=1 carrying C(pc=7) -> next cycle id_valid=0, if_ready=1; C never appears; stall_cnt unchanged.
- Saturation: CNT_W=4, hold id_valid=1 and id_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Random valid/ready with occasional flush against a scoreboard reference model -> order preserved; no duplicates; id_inst=NOP_INST whenever id_valid=0.
